sccb_responder: RTL and testbench
=================================

SCCB_RESPONDER -- requirements
Module: sccb_responder

Interface
REQ-001 SHALL have parameter DEV_ID, default 8'h42, 7-bit device address in bits [7:1]; bit 0 is ignored on compare.
REQ-002 SHALL have parameter HOLD_CYCLES, default 8, clk cycles from a detected SIOC falling edge to any SIOD drive change.
REQ-003 clk  input  1  system clock, at least 20x the SIOC frequency.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 sioc_i  input  1  SCCB clock from the bus; asynchronous to clk.
REQ-006 siod_i  input  1  SCCB data sampled from the bus; asynchronous to clk.
REQ-007 siod_oe  output  1  1 = pull SIOD low; 0 = release. Open-drain; the pad drives only 0.
REQ-008 wr_valid  output  1  one-clk pulse when a register write commits.
REQ-009 wr_addr / wr_data  output  8 / 8  address and data of the committed write; held until the next write.
REQ-010 rd_valid  output  1  one-clk pulse when a read byte is loaded for transmission.
REQ-011 busy  output  1  high from START detection until STOP detection or abort.

Function
REQ-012 SHALL synchronize sioc_i and siod_i through 2 flops, then detect edges on the synchronized signals.
REQ-013 START: SHALL detect synced SIOD falling while synced SIOC is high. START is accepted in every state (repeated start), clears the bit counter, and enters ID.
REQ-014 STOP: SHALL detect synced SIOD rising while synced SIOC is high. STOP from any state SHALL enter IDLE, release siod_oe, and deassert busy.
REQ-015 SHALL sample data bits on SIOC rising edges, MSB first, using a 3-bit counter and an 8-bit shift register.
REQ-016 States: IDLE, ID, ID_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RD_NA, WAIT_STOP.
REQ-017 ID: after 8 bits, if byte[7:1]==DEV_ID[7:1], SHALL go to ID_ACK with bit0 latched as the direction (1 = read). On mismatch SHALL go to WAIT_STOP with no ack.
REQ-018 Ack/9th bit: in *_ACK states, SHALL assert siod_oe HOLD_CYCLES after the SIOC falling edge that ends bit 8, and release it HOLD_CYCLES after the next SIOC falling edge.
REQ-019 After ID_ACK: a write SHALL go to SUB; a read SHALL go to RDATA.
REQ-020 After SUB: SHALL load an 8-bit address pointer, go to SUB_ACK, then go to WDATA.
REQ-021 After WDATA: SHALL write regfile[ptr], pulse wr_valid, go to WDATA_ACK, then go to WAIT_STOP. Bytes after the third phase SHALL be ignored and not acked.
REQ-022 2-phase write (ID, SUB, STOP) SHALL update only the pointer; no wr_valid.
REQ-023 RDATA: on the ID_ACK release edge, SHALL load regfile[ptr] and pulse rd_valid.
REQ-024 RDATA: SHALL drive each bit (siod_oe = ~bit) HOLD_CYCLES after each SIOC falling edge, MSB first.
REQ-025 RD_NA: SHALL release SIOD, ignore the master's NA/A bit, and go to WAIT_STOP.
REQ-026 The pointer SHALL NOT auto-increment on either reads or writes.
REQ-027 Regfile: 256x8 flops. Reset values are 0 except 0x0A=8'h76 and 0x0B=8'h73 (PID/VER).
REQ-028 A SIOC edge and a START/STOP in the same clk: START/STOP SHALL take priority.

Reset
REQ-029 On rst_n low: state=IDLE, siod_oe=0, busy=0, wr_valid=0, rd_valid=0, wr_addr=0, wr_data=0, ptr=0, regfile to REQ-027 values, and synchronizer flops to 1 (idle bus).
REQ-030 Reset mid-transfer SHALL release SIOD within one clk of assertion (asynchronous path).

Structure
REQ-031 SCCB state encoding, PID/VER constants, and the default DEV_ID SHALL live in the shared sccb package.
REQ-032 Regfile SHALL be a sub-module sccb_regfile with one synchronous write port and one read port.

Verification
REQ-033 3-phase write ID 0x42, SUB 0x12, DATA 0x80 at 100 kHz -> three acks (SIOD low); wr_valid pulses once with wr_addr=0x12, wr_data=0x80.
REQ-034 2-phase write 0x42/0x0A, STOP, then 2-phase read 0x43 -> one ack; rd_valid pulses; bits shifted out equal 0x76; no wr_valid.
REQ-035 ID 0x60 -> siod_oe stays 0 for the whole transaction; busy falls at STOP; regfile unchanged.
REQ-036 Repeated START after SUB 0x0B, then ID 0x43 -> reads 0x73.
REQ-037 rst_n asserted during an RDATA low bit -> siod_oe=0 immediately; the next transaction completes normally.
REQ-038 Fourth data byte 0x55 after a 3-phase write -> not acked; exactly one wr_valid pulse.

Source files
------------

// File: rtl/sccb_responder_pkg.sv
// Shared SCCB definitions: FSM encoding, device identity and
// register reset contents for the SCCB responder slice.
package sccb_responder_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ID,
        S_ID_ACK,
        S_SUB,
        S_SUB_ACK,
        S_WDATA,
        S_WDATA_ACK,
        S_RDATA,
        S_RD_NA,
        S_WAIT_STOP
    } sccb_state_e;

    localparam logic [7:0] DEV_ID_DEF = 8'h42;
    localparam logic [7:0] PID_ADDR   = 8'h0A;
    localparam logic [7:0] VER_ADDR   = 8'h0B;
    localparam logic [7:0] PID_VAL    = 8'h76;
    localparam logic [7:0] VER_VAL    = 8'h73;

    function automatic logic [7:0] reg_reset_val(input logic [7:0] a);
        logic [7:0] v;
        v = 8'h00;
        if (a == PID_ADDR) v = PID_VAL;
        if (a == VER_ADDR) v = VER_VAL;
        return v;
    endfunction

endpackage

// File: rtl/sccb_responder_regfile.sv
// 256x8 flop register file, one synchronous write port and one
// combinational read port; PID/VER come up with their fixed values.
module sccb_regfile
    import sccb_responder_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we_i,
    input  logic [7:0] waddr_i,
    input  logic [7:0] wdata_i,
    input  logic [7:0] raddr_i,
    output logic [7:0] rdata_o
);

    logic [7:0] mem_q [256];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) begin
                mem_q[i] <= reg_reset_val(8'(i));
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sccb_responder.sv
// SCCB (3-wire camera bus) responder: synchronises the bus, decodes
// ID/sub-address/data phases and serves a 256-byte register file.
module sccb_responder
    import sccb_responder_pkg::*;
#(
    parameter logic [7:0]  DEV_ID      = DEV_ID_DEF,
    parameter int unsigned HOLD_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sioc_i,
    input  logic       siod_i,
    output logic       siod_oe,
    output logic       wr_valid,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       rd_valid,
    output logic       busy
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);

    logic [2:0] sioc_q, siod_q;
    logic       sioc, sioc_p, siod, siod_p;
    logic       sioc_rise, sioc_fall, start, stop;

    sccb_state_e state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  sh_q, sh_d;
    logic [7:0]  ptr_q, ptr_d;
    logic        dir_q, dir_d;
    logic [HW-1:0] hold_q, hold_d;
    logic        pend_q, pend_d;
    logic        oe_q, oe_d;
    logic        wr_valid_q, wr_valid_d;
    logic        rd_valid_q, rd_valid_d;
    logic [7:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        we;
    logic [7:0]  byte_in;
    logic [7:0]  rdata;

    // [1] is the synchronised level, [2] the previous one for edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sioc_q <= 3'b111;
            siod_q <= 3'b111;
        end else begin
            sioc_q <= {sioc_q[1:0], sioc_i};
            siod_q <= {siod_q[1:0], siod_i};
        end
    end

    assign sioc      = sioc_q[1];
    assign sioc_p    = sioc_q[2];
    assign siod      = siod_q[1];
    assign siod_p    = siod_q[2];
    assign sioc_rise = sioc & ~sioc_p;
    assign sioc_fall = ~sioc & sioc_p;
    assign start     = sioc & siod_p & ~siod;
    assign stop      = sioc & ~siod_p & siod;

    sccb_regfile u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (we),
        .waddr_i (ptr_q),
        .wdata_i (byte_in),
        .raddr_i (ptr_q),
        .rdata_o (rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            sh_q       <= '0;
            ptr_q      <= '0;
            dir_q      <= 1'b0;
            hold_q     <= '0;
            pend_q     <= 1'b0;
            oe_q       <= 1'b0;
            wr_valid_q <= 1'b0;
            rd_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sh_q       <= sh_d;
            ptr_q      <= ptr_d;
            dir_q      <= dir_d;
            hold_q     <= hold_d;
            pend_q     <= pend_d;
            oe_q       <= oe_d;
            wr_valid_q <= wr_valid_d;
            rd_valid_q <= rd_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sh_d       = sh_q;
        ptr_d      = ptr_q;
        dir_d      = dir_q;
        hold_d     = hold_q;
        pend_d     = pend_q;
        oe_d       = oe_q;
        wr_valid_d = 1'b0;
        rd_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        we         = 1'b0;
        byte_in    = {sh_q[6:0], siod};

        // Every SIOC fall arms the timer; the drive change lands on expiry
        if (hold_q != '0) begin
            hold_d = hold_q - HW'(1);
            if (hold_q == HW'(1)) oe_d = pend_q;
        end

        if (start) begin
            state_d = S_ID;
            cnt_d   = '0;
            hold_d  = '0;
            oe_d    = 1'b0;
        end else if (stop) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            hold_d  = '0;
            oe_d    = 1'b0;
        end else if (sioc_rise) begin
            case (state_q)
                S_ID, S_SUB, S_WDATA: begin
                    sh_d  = byte_in;
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        if (state_q == S_ID) begin
                            if (byte_in[7:1] == DEV_ID[7:1]) begin
                                state_d = S_ID_ACK;
                                dir_d   = byte_in[0];
                            end else begin
                                state_d = S_WAIT_STOP;
                            end
                        end else if (state_q == S_SUB) begin
                            ptr_d   = byte_in;
                            state_d = S_SUB_ACK;
                        end else begin
                            we         = 1'b1;
                            wr_valid_d = 1'b1;
                            wr_addr_d  = ptr_q;
                            wr_data_d  = byte_in;
                            state_d    = S_WDATA_ACK;
                        end
                    end
                end
                S_ID_ACK, S_SUB_ACK, S_WDATA_ACK: cnt_d = 3'd1;
                S_RDATA: begin
                    if (cnt_q == 3'd7) begin
                        state_d = S_RD_NA;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                        sh_d  = {sh_q[6:0], 1'b0};
                    end
                end
                S_RD_NA: state_d = S_WAIT_STOP;
                default: ;
            endcase
        end else if (sioc_fall) begin
            hold_d = HW'(HOLD_CYCLES);
            pend_d = 1'b0;
            case (state_q)
                S_ID_ACK, S_SUB_ACK, S_WDATA_ACK: begin
                    // cnt==0: fall ending bit 8; otherwise fall ending the ack
                    if (cnt_q == 3'd0) begin
                        pend_d = 1'b1;
                    end else begin
                        cnt_d = '0;
                        if (state_q == S_ID_ACK) begin
                            if (dir_q) begin
                                state_d    = S_RDATA;
                                sh_d       = rdata;
                                rd_valid_d = 1'b1;
                                pend_d     = ~rdata[7];
                            end else begin
                                state_d = S_SUB;
                            end
                        end else if (state_q == S_SUB_ACK) begin
                            state_d = S_WDATA;
                        end else begin
                            state_d = S_WAIT_STOP;
                        end
                    end
                end
                S_RDATA: pend_d = ~sh_q[7];
                default: ;
            endcase
        end
    end

    assign siod_oe  = oe_q;
    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign rd_valid = rd_valid_q;
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_sccb_responder.sv
// Directed bench for sccb_responder: a bit-banged SCCB master at
// 100 kHz against a ~5.5 MHz system clock.
module tb_sccb_responder;

    localparam int Q = 2500;

    logic       clk;
    logic       rst_n;
    logic       m_scl;
    logic       m_sda;
    logic       sioc_i;
    logic       siod_i;
    logic       siod_oe;
    logic       wr_valid;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_valid;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int oe_cnt = 0;
    int oe_base;
    logic       ack;
    logic [7:0] rb;

    assign sioc_i = m_scl;
    assign siod_i = m_sda & ~siod_oe;

    sccb_responder #(
        .DEV_ID      (8'h42),
        .HOLD_CYCLES (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sioc_i   (sioc_i),
        .siod_i   (siod_i),
        .siod_oe  (siod_oe),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_valid (rd_valid),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #90 clk = ~clk;
    end

    always @(posedge clk) begin
        if (wr_valid) wr_cnt++;
        if (rd_valid) rd_cnt++;
        if (siod_oe)  oe_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus_start();
        if (m_scl == 1'b0) begin
            m_sda = 1'b1;
            #(Q);
            m_scl = 1'b1;
            #(Q);
        end
        m_sda = 1'b0;
        #(Q);
        m_scl = 1'b0;
        #(Q);
    endtask

    task automatic bus_stop();
        m_sda = 1'b0;
        #(Q);
        m_scl = 1'b1;
        #(Q);
        m_sda = 1'b1;
        #(Q);
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic a);
        for (int i = 7; i >= 0; i--) begin
            m_sda = b[i];
            #(2 * Q);
            m_scl = 1'b1;
            #(2 * Q);
            m_scl = 1'b0;
        end
        m_sda = 1'b1;
        #(2 * Q);
        m_scl = 1'b1;
        #(Q);
        a = (siod_i == 1'b0);
        #(Q);
        m_scl = 1'b0;
    endtask

    task automatic rd_byte(output logic [7:0] b);
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            m_sda = 1'b1;
            #(2 * Q);
            m_scl = 1'b1;
            #(Q);
            b = {b[6:0], siod_i};
            #(Q);
            m_scl = 1'b0;
        end
        m_sda = 1'b1;
        #(2 * Q);
        m_scl = 1'b1;
        #(2 * Q);
        m_scl = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        m_scl = 1'b1;
        m_sda = 1'b1;
        #(Q);
        check("rst_oe", siod_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_wr_valid", wr_valid, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        rst_n = 1'b1;
        #(2 * Q);

        // 3-phase write
        bus_start();
        check("busy_start", busy, 1);
        wr_byte(8'h42, ack);
        check("w3_id_ack", ack, 1);
        wr_byte(8'h12, ack);
        check("w3_sub_ack", ack, 1);
        wr_byte(8'h80, ack);
        check("w3_data_ack", ack, 1);
        bus_stop();
        check("w3_busy_stop", busy, 0);
        check("w3_wr_cnt", wr_cnt, 1);
        check("w3_wr_addr", wr_addr, 8'h12);
        check("w3_wr_data", wr_data, 8'h80);

        // pointer set then read PID
        bus_start();
        wr_byte(8'h42, ack);
        check("p_id_ack", ack, 1);
        wr_byte(8'h0A, ack);
        check("p_sub_ack", ack, 1);
        bus_stop();
        bus_start();
        wr_byte(8'h43, ack);
        check("r_id_ack", ack, 1);
        rd_byte(rb);
        check("r_pid", rb, 8'h76);
        bus_stop();
        check("r_rd_cnt", rd_cnt, 1);
        check("r_no_write", wr_cnt, 1);

        // foreign device id
        oe_base = oe_cnt;
        bus_start();
        wr_byte(8'h60, ack);
        check("f_id_noack", ack, 0);
        wr_byte(8'h12, ack);
        check("f_sub_noack", ack, 0);
        check("f_busy_mid", busy, 1);
        bus_stop();
        check("f_oe_never", oe_cnt - oe_base, 0);
        check("f_busy_stop", busy, 0);
        check("f_wr_cnt", wr_cnt, 1);
        bus_start();
        wr_byte(8'h42, ack);
        wr_byte(8'h12, ack);
        bus_stop();
        bus_start();
        wr_byte(8'h43, ack);
        rd_byte(rb);
        bus_stop();
        check("f_reg12_kept", rb, 8'h80);

        // repeated start
        bus_start();
        wr_byte(8'h42, ack);
        wr_byte(8'h0B, ack);
        check("rs_sub_ack", ack, 1);
        bus_start();
        wr_byte(8'h43, ack);
        check("rs_id_ack", ack, 1);
        rd_byte(rb);
        check("rs_ver", rb, 8'h73);
        bus_stop();
        check("rs_rd_cnt", rd_cnt, 3);

        // extra byte after a complete write
        bus_start();
        wr_byte(8'h42, ack);
        wr_byte(8'h20, ack);
        wr_byte(8'h33, ack);
        check("x_data_ack", ack, 1);
        wr_byte(8'h55, ack);
        check("x_4th_noack", ack, 0);
        bus_stop();
        check("x_wr_cnt", wr_cnt, 2);
        check("x_wr_addr", wr_addr, 8'h20);
        check("x_wr_data", wr_data, 8'h33);

        // reset while driving a low read bit
        bus_start();
        wr_byte(8'h42, ack);
        wr_byte(8'h0A, ack);
        bus_stop();
        bus_start();
        wr_byte(8'h43, ack);
        m_sda = 1'b1;
        #(2 * Q);
        check("ar_oe_low_bit", siod_oe, 1);
        rst_n = 1'b0;
        #1;
        check("ar_oe_released", siod_oe, 0);
        check("ar_busy", busy, 0);
        m_scl = 1'b1;
        #(Q);
        m_sda = 1'b1;
        #(Q);
        rst_n = 1'b1;
        #(Q);
        bus_start();
        wr_byte(8'h42, ack);
        check("ar_id_ack", ack, 1);
        wr_byte(8'h30, ack);
        wr_byte(8'h5A, ack);
        check("ar_data_ack", ack, 1);
        bus_stop();
        check("ar_wr_cnt", wr_cnt, 3);
        check("ar_wr_data", wr_data, 8'h5A);
        bus_start();
        wr_byte(8'h42, ack);
        wr_byte(8'h12, ack);
        bus_stop();
        bus_start();
        wr_byte(8'h43, ack);
        rd_byte(rb);
        bus_stop();
        check("ar_reg12_reset", rb, 8'h00);
        bus_start();
        wr_byte(8'h42, ack);
        wr_byte(8'h30, ack);
        bus_stop();
        bus_start();
        wr_byte(8'h43, ack);
        rd_byte(rb);
        bus_stop();
        check("ar_reg30", rb, 8'h5A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
